// File: rtl/vram_wb_dp.sv
// Dual-port video RAM: Wishbone classic slave for the CPU, pipelined read-only scan port for VGA.
// Both ports share one clock; the VGA port never stalls and reads first on a same-index write.
module vram_wb_dp #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1200,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned VGA_LAT   = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   dat_i,
    input  logic [31:0]         adr_i,
    input  logic [DATA_W/8-1:0] sel_i,
    input  logic                we_i,
    input  logic                stb_i,
    input  logic                cyc_i,
    output logic [DATA_W-1:0]   dat_o,
    output logic                ack_o,
    output logic                err_o,
    input  logic                vga_en,
    input  logic [ADDR_W-1:0]   vga_addr,
    output logic [DATA_W-1:0]   vga_dout,
    output logic                vga_valid
);

    localparam int unsigned SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] vga_word_q;
    logic              vga_en_q;
    logic [ADDR_W-1:0] idx;
    logic              idx_ok;
    logic              vga_ok;
    logic              req;
    logic              wr_en;
    logic              rd_en;
    logic              rd_cap;
    logic              unused_adr;

    assign idx        = adr_i[ADDR_W+1:2];
    assign idx_ok     = 32'(idx) < DEPTH;
    assign vga_ok     = 32'(vga_addr) < DEPTH;
    assign req        = cyc_i & stb_i;
    assign unused_adr = ^{adr_i[31:ADDR_W+2], adr_i[1:0]};

    // Bus handshake: next state and memory strobes
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_cap  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!idx_ok) begin
                        state_d = ERR;
                    end else if (we_i) begin
                        wr_en   = 1'b1;
                        state_d = ACK;
                    end else begin
                        rd_en   = 1'b1;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (req) begin
                    rd_cap  = 1'b1;
                    state_d = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            dat_o   <= '0;
        end else begin
            state_q <= state_d;
            ack_o   <= (state_d == ACK);
            err_o   <= (state_d == ERR);
            if (rd_cap) begin
                dat_o <= rd_word;
            end
        end
    end

    // Memory array is not reset; byte-lane write plus registered CPU read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (sel_i[b]) begin
                    mem[idx][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_word <= mem[idx];
        end
    end

    // VGA first stage; non-blocking read gives the pre-write word on a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_en_q   <= 1'b0;
            vga_word_q <= '0;
        end else begin
            vga_en_q <= vga_en;
            if (vga_en) begin
                vga_word_q <= vga_ok ? mem[vga_addr] : '0;
            end
        end
    end

    if (VGA_LAT == 2) begin : g_lat2
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vga_valid <= 1'b0;
                vga_dout  <= '0;
            end else begin
                vga_valid <= vga_en_q;
                if (vga_en_q) begin
                    vga_dout <= vga_word_q;
                end
            end
        end
    end else begin : g_lat1
        assign vga_valid = vga_en_q;
        assign vga_dout  = vga_word_q;
    end

endmodule

// File: tb/tb_vram_wb_dp.sv
// Directed bench for vram_wb_dp: two instances (VGA_LAT 1 and 2) share every input.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_vram_wb_dp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] dat_i;
    logic [31:0]       adr_i;
    logic [3:0]        sel_i;
    logic              we_i, stb_i, cyc_i;
    logic              vga_en;
    logic [ADDR_W-1:0] vga_addr;

    logic [DATA_W-1:0] dat_o1, dat_o2, vga_dout1, vga_dout2;
    logic              ack1, ack2, err1, err2, vga_valid1, vga_valid2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vram_wb_dp #(.DATA_W(32), .DEPTH(1200), .ADDR_W(11), .VGA_LAT(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst_n(rst_n), .dat_i(dat_i), .adr_i(adr_i), .sel_i(sel_i),
        .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .dat_o(dat_o1), .ack_o(ack1),
        .err_o(err1), .vga_en(vga_en), .vga_addr(vga_addr), .vga_dout(vga_dout1),
        .vga_valid(vga_valid1)
    );

    vram_wb_dp #(.DATA_W(32), .DEPTH(1200), .ADDR_W(11), .VGA_LAT(2), .INIT_FILE("")) dut2 (
        .clk(clk), .rst_n(rst_n), .dat_i(dat_i), .adr_i(adr_i), .sel_i(sel_i),
        .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .dat_o(dat_o2), .ack_o(ack2),
        .err_o(err2), .vga_en(vga_en), .vga_addr(vga_addr), .vga_dout(vga_dout2),
        .vga_valid(vga_valid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        sel_i = 4'h0; dat_i = '0;   adr_i = '0;
    endtask

    task automatic bus_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w;
        adr_i = a;    dat_i = d;    sel_i = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_idle(); vga_en = 1'b0; vga_addr = '0;
        repeat (3) tick();
        n_vec++;
        if ({ack1, err1, vga_valid1, ack2, err2, vga_valid2} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 000000",
                              {ack1, err1, vga_valid1, ack2, err2, vga_valid2});
        end
        n_vec++;
        if ({dat_o1, vga_dout1, vga_dout2} !== 96'h0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h want 0", dat_o1, vga_dout1, vga_dout2);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_vec++;
        if ({ack1, err1} !== 2'b00) begin
            n_err++; $display("FAIL idle_flags: got %b want 00", {ack1, err1});
        end
        // Reset while a read sits in RD_WAIT
        bus_req(1'b0, 32'h14, 32'h0, 4'h0);
        tick();
        n_vec++;
        if (dut1.state_q !== 2'd1) begin
            n_err++; $display("FAIL rdwait_entry: got %0d want 1", dut1.state_q);
        end
        #2 rst_n = 1'b0;
        bus_idle();
        #1;
        n_vec++;
        if (dut1.state_q !== 2'd0 || ack1 !== 1'b0) begin
            n_err++; $display("FAIL reset_midread: state %0d ack %b want 0 0", dut1.state_q, ack1);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) tick();
        n_vec++;
        if (ack1 !== 1'b0 || dat_o1 !== 32'h0) begin
            n_err++; $display("FAIL post_reset_noack: ack %b dat %h want 0 0", ack1, dat_o1);
        end
    endtask

    task automatic test_write_read();
        bus_req(1'b1, 32'h14, 32'hDEADBEEF, 4'hF);
        tick();
        n_vec++;
        if (ack1 !== 1'b1 || ack2 !== 1'b1) begin
            n_err++; $display("FAIL wr_ack: got %b%b want 11", ack1, ack2);
        end
        n_vec++;
        if (dat_o1 !== 32'h0) begin
            n_err++; $display("FAIL wr_no_dat: got %h want 00000000", dat_o1);
        end
        bus_idle();
        tick();
        n_vec++;
        if (ack1 !== 1'b0) begin
            n_err++; $display("FAIL wr_ack_pulse: got %b want 0", ack1);
        end
        bus_req(1'b0, 32'h14, 32'h0, 4'h0);
        tick();
        n_vec++;
        if (ack1 !== 1'b0) begin
            n_err++; $display("FAIL rd_ack_early: got %b want 0", ack1);
        end
        tick();
        n_vec++;
        if (ack1 !== 1'b1 || dat_o1 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL rd_full: ack %b dat %h want 1 deadbeef", ack1, dat_o1);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_byte_sel();
        bus_req(1'b1, 32'h14, 32'h11223344, 4'b0101);
        tick();
        bus_idle();
        tick();
        // Upper address bits are ignored: 0x2014 still hits index 5
        bus_req(1'b0, 32'h2014, 32'h0, 4'h0);
        repeat (2) tick();
        n_vec++;
        if (ack1 !== 1'b1 || dat_o1 !== 32'hDE22BE44) begin
            n_err++; $display("FAIL byte_sel: ack %b dat %h want 1 de22be44", ack1, dat_o1);
        end
        bus_idle();
        tick();
        bus_req(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0);
        tick();
        n_vec++;
        if (ack1 !== 1'b1) begin
            n_err++; $display("FAIL sel0_ack: got %b want 1", ack1);
        end
        bus_idle();
        tick();
        bus_req(1'b1, 32'h12BC, 32'h0BADF00D, 4'hF);
        tick();
        bus_idle();
        tick();
        bus_req(1'b0, 32'h12BC, 32'h0, 4'h0);
        repeat (2) tick();
        n_vec++;
        if (ack1 !== 1'b1 || dat_o1 !== 32'h0BADF00D) begin
            n_err++; $display("FAIL last_index: ack %b dat %h want 1 0badf00d", ack1, dat_o1);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_range_err();
        bus_req(1'b0, 32'h12C0, 32'h0, 4'h0);
        tick();
        n_vec++;
        if (err1 !== 1'b1 || ack1 !== 1'b0) begin
            n_err++; $display("FAIL oor_rd: err %b ack %b want 1 0", err1, ack1);
        end
        bus_idle();
        tick();
        n_vec++;
        if (err1 !== 1'b0 || ack1 !== 1'b0) begin
            n_err++; $display("FAIL oor_pulse: err %b ack %b want 0 0", err1, ack1);
        end
        bus_req(1'b1, 32'h1FFC, 32'h12345678, 4'hF);
        tick();
        n_vec++;
        if (err1 !== 1'b1 || ack1 !== 1'b0) begin
            n_err++; $display("FAIL oor_wr: err %b ack %b want 1 0", err1, ack1);
        end
        bus_idle();
        tick();
        bus_req(1'b0, 32'h14, 32'h0, 4'h0);
        repeat (2) tick();
        n_vec++;
        if (dat_o1 !== 32'hDE22BE44) begin
            n_err++; $display("FAIL oor_mem_kept: got %h want de22be44", dat_o1);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_vga();
        vga_en = 1'b1; vga_addr = 11'd5;
        tick();
        n_vec++;
        if (vga_valid1 !== 1'b1 || vga_dout1 !== 32'hDE22BE44) begin
            n_err++; $display("FAIL vga1_lat: v %b d %h want 1 de22be44", vga_valid1, vga_dout1);
        end
        n_vec++;
        if (vga_valid2 !== 1'b0 || vga_dout2 !== 32'h0) begin
            n_err++; $display("FAIL vga2_early: v %b d %h want 0 0", vga_valid2, vga_dout2);
        end
        tick();
        n_vec++;
        if (vga_valid2 !== 1'b1 || vga_dout2 !== 32'hDE22BE44) begin
            n_err++; $display("FAIL vga2_lat: v %b d %h want 1 de22be44", vga_valid2, vga_dout2);
        end
        // Same-edge CPU write to the index being scanned
        bus_req(1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
        tick();
        n_vec++;
        if (vga_dout1 !== 32'hDE22BE44 || ack1 !== 1'b1) begin
            n_err++; $display("FAIL vga1_collide: d %h ack %b want de22be44 1", vga_dout1, ack1);
        end
        bus_idle();
        tick();
        n_vec++;
        if (vga_dout1 !== 32'hCAFEF00D || vga_dout2 !== 32'hDE22BE44) begin
            n_err++; $display("FAIL vga_after_collide: d1 %h d2 %h want cafef00d de22be44",
                              vga_dout1, vga_dout2);
        end
        tick();
        n_vec++;
        if (vga_dout2 !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL vga2_new: got %h want cafef00d", vga_dout2);
        end
        vga_en = 1'b0;
        tick();
        n_vec++;
        if (vga_valid1 !== 1'b0 || vga_dout1 !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL vga1_hold: v %b d %h want 0 cafef00d", vga_valid1, vga_dout1);
        end
        vga_en = 1'b1; vga_addr = 11'd1200;
        tick();
        n_vec++;
        if (vga_valid1 !== 1'b1 || vga_dout1 !== 32'h0) begin
            n_err++; $display("FAIL vga1_oor: v %b d %h want 1 0", vga_valid1, vga_dout1);
        end
        vga_en = 1'b0; vga_addr = '0;
        repeat (2) tick();
        n_vec++;
        if (vga_valid2 !== 1'b0 || vga_dout2 !== 32'h0) begin
            n_err++; $display("FAIL vga2_oor_hold: v %b d %h want 0 0", vga_valid2, vga_dout2);
        end
    endtask

    task automatic test_abort();
        bus_req(1'b0, 32'h14, 32'h0, 4'h0);
        tick();
        stb_i = 1'b0;
        tick();
        n_vec++;
        if (ack1 !== 1'b0 || dat_o1 !== 32'hDE22BE44) begin
            n_err++; $display("FAIL abort_noack: ack %b dat %h want 0 de22be44", ack1, dat_o1);
        end
        bus_idle();
        tick();
        n_vec++;
        if (ack1 !== 1'b0 || err1 !== 1'b0) begin
            n_err++; $display("FAIL abort_quiet: ack %b err %b want 0 0", ack1, err1);
        end
        bus_req(1'b0, 32'h14, 32'h0, 4'h0);
        tick();
        n_vec++;
        if (ack1 !== 1'b0) begin
            n_err++; $display("FAIL abort_next_early: got %b want 0", ack1);
        end
        tick();
        n_vec++;
        if (ack1 !== 1'b1 || dat_o1 !== 32'hCAFEF00D || dat_o2 !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL abort_next: ack %b d1 %h d2 %h want 1 cafef00d cafef00d",
                              ack1, dat_o1, dat_o2);
        end
        bus_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_sel();
        test_range_err();
        test_vga();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
